// File: rtl/dice_roll_capture.sv
// dice_roll_capture: detects the end of a dice roll (button release), waits
// for the dice value to settle, then captures and reports the throw. Keeps
// saturating per-face and total tallies and drives a 7-segment pattern of
// the last captured result.
module dice_roll_capture #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  input  logic [2:0]       face_count_sel,
  output logic [2:0]       result,
  output logic             result_valid,
  output logic             rolling,
  output logic [6:0]       seg,
  output logic [CNT_W-1:0] face_count,
  output logic [CNT_W-1:0] total_rolls,
  output logic             error
);

  localparam int              SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    SETTLE,
    REPORT
  } state_t;

  state_t           state;
  logic [SC_W-1:0]  settle_cnt;
  logic [CNT_W-1:0] face_cnt [1:6];
  logic             throw_legal;

  assign throw_legal = (throw != 3'd0) && (throw != 3'd7);

  function automatic logic [6:0] seg_decode(input logic [2:0] v);
    case (v)
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b1101101;
      3'd3:    return 7'b1111001;
      3'd4:    return 7'b0110011;
      3'd5:    return 7'b1011011;
      3'd6:    return 7'b1011111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Roll-tracking FSM with registered result, segment, tally and flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      rolling      <= 1'b0;
      seg          <= '0;
      total_rolls  <= '0;
      error        <= 1'b0;
      for (int unsigned f = 1; f <= 6; f++) begin
        face_cnt[f] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (button) begin
            state   <= ROLLING;
            rolling <= 1'b1;
          end
        end
        ROLLING: begin
          if (!button) begin
            state      <= SETTLE;
            settle_cnt <= SC_LOAD;
          end
        end
        SETTLE: begin
          if (button) begin
            state <= ROLLING;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SC_ONE;
          end else begin
            state   <= REPORT;
            rolling <= 1'b0;
            if (throw_legal) begin
              result       <= throw;
              seg          <= seg_decode(throw);
              result_valid <= 1'b1;
              if (total_rolls != CNT_MAX) begin
                total_rolls <= total_rolls + CNT_ONE;
              end
              for (int unsigned f = 1; f <= 6; f++) begin
                if (throw == 3'(f) && face_cnt[f] != CNT_MAX) begin
                  face_cnt[f] <= face_cnt[f] + CNT_ONE;
                end
              end
            end else begin
              error <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (button) begin
            state   <= ROLLING;
            rolling <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          rolling <= 1'b0;
        end
      endcase
    end
  end

  // Combinational tally readback; selects 0 and 7 read as zero
  always_comb begin
    face_count = '0;
    for (int unsigned f = 1; f <= 6; f++) begin
      if (face_count_sel == 3'(f)) begin
        face_count = face_cnt[f];
      end
    end
  end

endmodule

// File: tb/tb_dice_roll_capture.sv
// Self-checking bench for dice_roll_capture: a scoreboard queue holds the
// expected capture value and the cycle it must appear in; a negedge monitor
// pops it on each result_valid pulse. Tallies are tracked by a small model.
module tb_dice_roll_capture;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 2;
  localparam int MAXC   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             button;
  logic [2:0]       throw;
  logic [2:0]       face_count_sel;
  logic [2:0]       result;
  logic             result_valid;
  logic             rolling;
  logic [6:0]       seg;
  logic [CNT_W-1:0] face_count;
  logic [CNT_W-1:0] total_rolls;
  logic             error;

  dice_roll_capture #(
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .throw         (throw),
    .face_count_sel(face_count_sel),
    .result        (result),
    .result_valid  (result_valid),
    .rolling       (rolling),
    .seg           (seg),
    .face_count    (face_count),
    .total_rolls   (total_rolls),
    .error         (error)
  );

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  val;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  int         exp_face [0:7];
  int         exp_total;
  logic       exp_err;
  logic [2:0] exp_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    if (obs !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  function automatic logic [6:0] seg_exp(input logic [2:0] v);
    case (v)
      3'd0:    return 7'b0000000;
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b1101101;
      3'd3:    return 7'b1111001;
      3'd4:    return 7'b0110011;
      3'd5:    return 7'b1011011;
      3'd6:    return 7'b1011111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Monitor: every valid pulse must match the oldest pending expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("stray_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("valid_value", 32'(result), 32'(e.val));
        check("valid_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) exp_face[i] = 0;
    exp_total = 0;
    exp_err   = 1'b0;
    exp_res   = 3'd0;
  endtask

  task automatic check_all(input logic exp_rolling);
    check("result", 32'(result), 32'(exp_res));
    check("seg", 32'(seg), 32'(seg_exp(exp_res)));
    check("total_rolls", 32'(total_rolls), 32'(exp_total));
    check("error", 32'(error), 32'(exp_err));
    check("rolling", 32'(rolling), 32'(exp_rolling));
    for (int s = 0; s < 8; s++) begin
      face_count_sel = 3'(s);
      #1;
      check("face_count", 32'(face_count), 32'(exp_face[s]));
    end
    face_count_sel = 3'd0;
  endtask

  // Hold button for `hold` cycles with throw t, release, then wait `wait_n`
  // negedges before checking (SETTLE+1 lands in the REPORT cycle).
  task automatic roll(input int hold, input logic [2:0] t, input int wait_n);
    exp_t e;
    button = 1'b1;
    throw  = t;
    tick(hold);
    check("rolling_hi", 32'(rolling), 32'd1);
    button = 1'b0;
    if (t != 3'd0 && t != 3'd7) begin
      e.val = t;
      e.due = cyc + 1 + SETTLE;
      sb.push_back(e);
      exp_res = t;
      if (exp_face[t] < MAXC) exp_face[t]++;
      if (exp_total < MAXC) exp_total++;
    end else begin
      exp_err = 1'b1;
    end
    tick(wait_n);
    check_all(1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    button         = 1'b0;
    throw          = 3'd0;
    face_count_sel = 3'd0;
    model_clear();

    // Reset held for 3 cycles
    tick(3);
    rst = 1'b0;
    check("valid_rst", 32'(result_valid), 32'd0);
    check_all(1'b0);

    // Basic capture of a 4
    roll(10, 3'd4, SETTLE + 3);

    // Bounces: short lows inside SETTLE must not capture
    for (int b = 1; b <= SETTLE; b++) begin
      button = 1'b1;
      throw  = 3'd3;
      tick(4);
      button = 1'b0;
      tick(b);
      check("rolling_bounce_lo", 32'(rolling), 32'd1);
      button = 1'b1;
      tick(1);
      check("rolling_bounce_hi", 32'(rolling), 32'd1);
      tick(SETTLE + 3);
      check("rolling_bounce_hold", 32'(rolling), 32'd1);
    end
    roll(3, 3'd6, SETTLE + 3);

    // Illegal throws set the sticky error only
    roll(4, 3'd7, SETTLE + 3);
    roll(4, 3'd0, SETTLE + 3);
    roll(4, 3'd2, SETTLE + 3);

    // Saturation, back-to-back rolls re-entering ROLLING from REPORT
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_clear();
    check_all(1'b0);
    for (int r = 0; r < 5; r++) roll(1, 3'd1, SETTLE + 1);
    roll(1, 3'd5, SETTLE + 3);

    // Reset in the middle of SETTLE with the button held high
    button = 1'b1;
    throw  = 3'd5;
    tick(3);
    button = 1'b0;
    tick(1);
    check("rolling_settle", 32'(rolling), 32'd1);
    rst    = 1'b1;
    button = 1'b1;
    tick(1);
    model_clear();
    check_all(1'b0);
    rst = 1'b0;
    tick(1);
    check("rolling_after_rst", 32'(rolling), 32'd1);
    tick(SETTLE + 3);
    check_all(1'b1);
    roll(2, 3'd3, SETTLE + 3);

    tick(2);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
